// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier
//   Sequential shift-add multiplier: controller FSM, A/B/X register chain and a (WIDTH+1)-bit
//   add/sub unit in one block. Multiplies the B register by a multiplicand S latched from Bin.
//   SIGNED=1 gives a two's-complement product (X is the sign extension of A); SIGNED=0 gives an
//   unsigned product (X is the carry out of the adder). The product is {Aout, Bout}.
//
// Ports
//   Clk           in   clock, rising edge
//   Reset         in   asynchronous, active-low reset
//   ClearA_LoadB  in   in IDLE: A<=0, X<=0, B<=Bin (has priority over Run)
//   Run           in   level; starts a multiply from IDLE, must drop to leave HALT
//   Bin           in   B load value and multiplicand S
//   Aout          out  A register (product upper half)
//   Bout          out  B register (product lower half)
//   X             out  extension bit above A
//   Busy          out  high in ADD/SHIFT
//   Done          out  high in HALT
//   State         out  0=IDLE 1=ADD 2=SHIFT 3=HALT
module seq_shift_add_multiplier #(
    parameter int unsigned WIDTH  = 8,
    parameter bit          SIGNED = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ClearA_LoadB,
    input  logic             Run,
    input  logic [WIDTH-1:0] Bin,
    output logic [WIDTH-1:0] Aout,
    output logic [WIDTH-1:0] Bout,
    output logic             X,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       State
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAdd   = 2'd1,
        StShift = 2'd2,
        StHalt  = 2'd3
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             x_q;
    logic [CW-1:0]    count_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   ext_a;
    logic [WIDTH:0]   ext_s;
    logic [WIDTH:0]   sum;
    logic             last_bit;

    assign last_bit = (count_q == LastCount);

    // The last partial product of a two's-complement multiplier carries negative weight,
    // so it is subtracted rather than added.
    always_comb begin
        ext_a = SIGNED ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
        ext_s = SIGNED ? {s_q[WIDTH-1], s_q} : {1'b0, s_q};
        sum   = (SIGNED && last_bit) ? (ext_a - ext_s) : (ext_a + ext_s);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            x_q     <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ClearA_LoadB) begin
                        a_q <= '0;
                        x_q <= 1'b0;
                        b_q <= Bin;
                    end else if (Run) begin
                        a_q     <= '0;
                        x_q     <= 1'b0;
                        s_q     <= Bin;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StAdd;
                    end
                end
                StAdd: begin
                    if (b_q[0]) begin
                        {x_q, a_q} <= sum;
                    end
                    state_q <= StShift;
                end
                StShift: begin
                    a_q <= {x_q, a_q[WIDTH-1:1]};
                    b_q <= {a_q[0], b_q[WIDTH-1:1]};
                    // Unsigned: the carry has been shifted into A and must not re-enter.
                    if (!SIGNED) begin
                        x_q <= 1'b0;
                    end
                    if (last_bit) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StHalt;
                    end else begin
                        count_q <= count_q + 1'b1;
                        state_q <= StAdd;
                    end
                end
                StHalt: begin
                    // Wait for Run to drop so one press yields exactly one multiply.
                    if (!Run) begin
                        done_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign Aout  = a_q;
    assign Bout  = b_q;
    assign X     = x_q;
    assign Busy  = busy_q;
    assign Done  = done_q;
    assign State = state_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
module tb_seq_shift_add_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       d8_clr, d8_run;
    logic [7:0] d8_bin, d8_a, d8_b;
    logic       d8_x, d8_busy, d8_done;
    logic [1:0] d8_state;
    logic       d4_clr, d4_run;
    logic [3:0] d4_bin, d4_a, d4_b;
    logic       d4_x, d4_busy, d4_done;
    logic [1:0] d4_state;

    int checks = 0;
    int passes = 0;
    logic [7:0] cur_b8;
    logic [3:0] cur_b4;

    seq_shift_add_multiplier #(.WIDTH(8), .SIGNED(1'b1)) u_dut8 (
        .Clk(clk), .Reset(rst_n), .ClearA_LoadB(d8_clr), .Run(d8_run), .Bin(d8_bin),
        .Aout(d8_a), .Bout(d8_b), .X(d8_x), .Busy(d8_busy), .Done(d8_done), .State(d8_state)
    );

    seq_shift_add_multiplier #(.WIDTH(4), .SIGNED(1'b0)) u_dut4 (
        .Clk(clk), .Reset(rst_n), .ClearA_LoadB(d4_clr), .Run(d4_run), .Bin(d4_bin),
        .Aout(d4_a), .Bout(d4_b), .X(d4_x), .Busy(d4_busy), .Done(d4_done), .State(d4_state)
    );

    // Reference: exact signed product, X equals the product sign.
    function automatic logic [16:0] model8(input logic [7:0] b, input logic [7:0] s);
        int sb, ss, p;
        logic [15:0] pw;
        sb = int'($signed(b));
        ss = int'($signed(s));
        p  = sb * ss;
        pw = p[15:0];
        return {pw[15], pw};
    endfunction

    // Reference: exact unsigned product, X ends at zero.
    function automatic logic [8:0] model4(input logic [3:0] b, input logic [3:0] s);
        int p;
        logic [7:0] pw;
        p  = int'(b) * int'(s);
        pw = p[7:0];
        return {1'b0, pw};
    endfunction

    task automatic load8(input logic [7:0] b);
        @(negedge clk);
        d8_clr = 1'b1; d8_run = 1'b0; d8_bin = b;
        @(negedge clk);
        d8_clr = 1'b0;
        cur_b8 = b;
        checks++;
        if ({d8_x, d8_a, d8_b, d8_state} !== {1'b0, 8'h00, b, 2'd0})
            $display("FAIL load8: got x=%b a=%h b=%h st=%0d required x=0 a=00 b=%h st=0",
                     d8_x, d8_a, d8_b, d8_state, b);
        else passes++;
    endtask

    task automatic load4(input logic [3:0] b);
        @(negedge clk);
        d4_clr = 1'b1; d4_run = 1'b0; d4_bin = b;
        @(negedge clk);
        d4_clr = 1'b0;
        cur_b4 = b;
        checks++;
        if ({d4_x, d4_a, d4_b, d4_state} !== {1'b0, 4'h0, b, 2'd0})
            $display("FAIL load4: got x=%b a=%h b=%h st=%0d required x=0 a=0 b=%h st=0",
                     d4_x, d4_a, d4_b, d4_state, b);
        else passes++;
    endtask

    // Starts a multiply at the current negedge; n counts edges with the Run edge as 1.
    task automatic mult8(input logic [7:0] s, input bit scramble, input bit hold_run);
        logic [16:0] exp;
        int n;
        bit seen;
        exp = model8(cur_b8, s);
        d8_run = 1'b1; d8_bin = s; d8_clr = 1'b0;
        seen = 0;
        n = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                checks++;
                if ({d8_busy, d8_done, d8_state} !== {1'b1, 1'b0, 2'd1})
                    $display("FAIL mult8_start: got busy=%b done=%b st=%0d required 1 0 1",
                             d8_busy, d8_done, d8_state);
                else passes++;
            end
            if (d8_done) begin
                seen = 1;
            end else begin
                if (!hold_run) d8_run = 1'b0;
                if (scramble && n < 16) begin
                    d8_bin = 8'($urandom);
                    d8_clr = 1'($urandom);
                end else begin
                    d8_clr = 1'b0;
                end
            end
        end
        checks++;
        if (n !== 17) $display("FAIL mult8_latency: got %0d edges required 17", n);
        else passes++;
        checks++;
        if ({d8_x, d8_a, d8_b} !== exp)
            $display("FAIL mult8_product b=%h s=%h: got x=%b a=%h b=%h required x=%b a=%h b=%h",
                     cur_b8, s, d8_x, d8_a, d8_b, exp[16], exp[15:8], exp[7:0]);
        else passes++;
        cur_b8 = exp[7:0];
        if (!hold_run) begin
            @(negedge clk);
            checks++;
            if ({d8_state, d8_done, d8_busy} !== {2'd0, 1'b0, 1'b0})
                $display("FAIL mult8_to_idle: got st=%0d done=%b busy=%b required 0 0 0",
                         d8_state, d8_done, d8_busy);
            else passes++;
        end
    endtask

    task automatic mult4(input logic [3:0] s);
        logic [8:0] exp;
        int n;
        bit seen;
        exp = model4(cur_b4, s);
        d4_run = 1'b1; d4_bin = s; d4_clr = 1'b0;
        seen = 0;
        n = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (d4_done) seen = 1;
            else begin
                d4_run = 1'b0;
                d4_bin = 4'($urandom);
            end
        end
        checks++;
        if (n !== 9) $display("FAIL mult4_latency: got %0d edges required 9", n);
        else passes++;
        checks++;
        if ({d4_x, d4_a, d4_b} !== exp)
            $display("FAIL mult4_product b=%h s=%h: got x=%b a=%h b=%h required x=%b a=%h b=%h",
                     cur_b4, s, d4_x, d4_a, d4_b, exp[8], exp[7:4], exp[3:0]);
        else passes++;
        cur_b4 = exp[3:0];
        @(negedge clk);
        checks++;
        if (d4_state !== 2'd0) $display("FAIL mult4_to_idle: got st=%0d required 0", d4_state);
        else passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        d8_clr = 0; d8_run = 0; d8_bin = '0;
        d4_clr = 0; d4_run = 0; d4_bin = '0;
        #2;
        checks++;
        if ({d8_x, d8_a, d8_b, d8_busy, d8_done, d8_state} !== 20'h0)
            $display("FAIL reset8: got x=%b a=%h b=%h busy=%b done=%b st=%0d required all 0",
                     d8_x, d8_a, d8_b, d8_busy, d8_done, d8_state);
        else passes++;
        checks++;
        if ({d4_x, d4_a, d4_b, d4_busy, d4_done, d4_state} !== 12'h0)
            $display("FAIL reset4: got x=%b a=%h b=%h busy=%b done=%b st=%0d required all 0",
                     d4_x, d4_a, d4_b, d4_busy, d4_done, d4_state);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        cur_b8 = '0;
        cur_b4 = '0;
    endtask

    task automatic test_directed();
        load8(8'h07);
        mult8(8'hC5, 1'b0, 1'b0);
        checks++;
        if ({d8_x, d8_a, d8_b} !== {1'b1, 8'hFE, 8'h63})
            $display("FAIL t1_const: got x=%b a=%h b=%h required x=1 a=fe b=63",
                     d8_x, d8_a, d8_b);
        else passes++;
        mult8(8'h02, 1'b0, 1'b0);
        checks++;
        if ({d8_x, d8_a, d8_b} !== {1'b0, 8'h00, 8'hC6})
            $display("FAIL t3_const: got x=%b a=%h b=%h required x=0 a=00 b=c6",
                     d8_x, d8_a, d8_b);
        else passes++;
        load8(8'hFF);
        mult8(8'hFF, 1'b0, 1'b0);
        load8(8'h80);
        mult8(8'h80, 1'b0, 1'b0);
        checks++;
        if ({d8_x, d8_a, d8_b} !== {1'b0, 8'h40, 8'h00})
            $display("FAIL t2_const: got x=%b a=%h b=%h required x=0 a=40 b=00",
                     d8_x, d8_a, d8_b);
        else passes++;
        load4(4'hF);
        mult4(4'hF);
        checks++;
        if ({d4_x, d4_a, d4_b} !== {1'b0, 4'hE, 4'h1})
            $display("FAIL t4_const: got x=%b a=%h b=%h required x=0 a=e b=1",
                     d4_x, d4_a, d4_b);
        else passes++;
        load4(4'h0);
        mult4(4'($urandom));
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            load8(8'($urandom));
            mult8(8'($urandom), 1'b1, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            load4(4'($urandom));
            mult4(4'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        load8(8'($urandom));
        for (int i = 0; i < 5; i++) mult8(8'($urandom), 1'b1, 1'b0);
        load4(4'($urandom));
        for (int i = 0; i < 3; i++) mult4(4'($urandom));
    endtask

    task automatic test_load_priority();
        @(negedge clk);
        d8_clr = 1'b1; d8_run = 1'b1; d8_bin = 8'h5A;
        @(negedge clk);
        d8_clr = 1'b0; d8_run = 1'b0;
        cur_b8 = 8'h5A;
        checks++;
        if ({d8_state, d8_busy, d8_a, d8_b} !== {2'd0, 1'b0, 8'h00, 8'h5A})
            $display("FAIL load_priority: got st=%0d busy=%b a=%h b=%h required 0 0 00 5a",
                     d8_state, d8_busy, d8_a, d8_b);
        else passes++;
    endtask

    task automatic test_halt_hold();
        load8(8'h07);
        mult8(8'hC5, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                d8_clr = 1'b1; d8_bin = 8'h33;
            end else begin
                d8_clr = 1'b0;
            end
            @(negedge clk);
            checks++;
            if ({d8_done, d8_state, d8_x, d8_a, d8_b} !== {1'b1, 2'd3, 1'b1, 8'hFE, 8'h63})
                $display("FAIL halt_hold[%0d]: got done=%b st=%0d x=%b a=%h b=%h required 1 3 1 fe 63",
                         i, d8_done, d8_state, d8_x, d8_a, d8_b);
            else passes++;
        end
        d8_clr = 1'b0; d8_run = 1'b0;
        @(negedge clk);
        checks++;
        if ({d8_state, d8_done} !== {2'd0, 1'b0})
            $display("FAIL halt_release: got st=%0d done=%b required 0 0", d8_state, d8_done);
        else passes++;
    endtask

    task automatic test_async_reset();
        load8(8'h07);
        d8_run = 1'b1; d8_bin = 8'hC5;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            d8_run = 1'b0;
        end
        checks++;
        if ({d8_state, d8_busy} !== {2'd2, 1'b1})
            $display("FAIL mid_shift: got st=%0d busy=%b required 2 1", d8_state, d8_busy);
        else passes++;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({d8_x, d8_a, d8_b, d8_busy, d8_done, d8_state} !== 20'h0)
            $display("FAIL async_reset: got x=%b a=%h b=%h busy=%b done=%b st=%0d required all 0",
                     d8_x, d8_a, d8_b, d8_busy, d8_done, d8_state);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        cur_b8 = '0;
        cur_b4 = '0;
        load8(8'h07);
        mult8(8'hC5, 1'b0, 1'b0);
        checks++;
        if ({d8_x, d8_a, d8_b} !== {1'b1, 8'hFE, 8'h63})
            $display("FAIL rerun_after_reset: got x=%b a=%h b=%h required x=1 a=fe b=63",
                     d8_x, d8_a, d8_b);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_load_priority();
        test_halt_hold();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
